// File: rtl/id_ex_pkg.sv
// Shared pipeline definitions for the ID/EX boundary: widths, ALU op codes, stage states.
package id_ex_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REG_W    = 5;
    localparam int ALUOP_W  = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA,
        ALU_CPY  = 4'hB,
        ALU_R0C  = 4'hC,
        ALU_R0D  = 4'hD,
        ALU_R0E  = 4'hE,
        ALU_R0F  = 4'hF
    } alu_op_e;

    // BUBBLE only exists when the load-use interlock is built in.
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_BUBBLE = 2'd2
    } stage_state_e;

    // Register x0 is hardwired to zero, so it can never carry a real dependency.
    function automatic logic is_live_reg(input logic [REG_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use compare between the held EX instruction and the incoming ID one.
module id_ex_hazard
    import id_ex_pkg::*;
(
    input  logic             in_valid,
    input  logic             held_valid,
    input  logic             held_memread,
    input  logic [REG_W-1:0] held_rd,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic             in_alusrc,
    output logic             hazard
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_live;

    assign load_live = held_valid & held_memread & is_live_reg(held_rd);
    assign rs1_hit   = (in_rs1 == held_rd);
    // rs2 is only read by the ALU when the immediate is not selected.
    assign rs2_hit   = (in_rs2 == held_rd) & ~in_alusrc;
    assign hazard    = in_valid & load_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with valid/ready handshake, flush and stall counter.
// Optional load-use interlock (one bubble) built when ID_EX_LOAD_USE_STALL_EN is defined.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [REG_W-1:0]   in_rs1,
    input  logic [REG_W-1:0]   in_rs2,
    input  logic [REG_W-1:0]   in_rd,
    input  logic               in_alusrc,
    input  logic               in_memread,
    input  logic               in_regwrite,
    input  logic [ALUOP_W-1:0] in_aluop,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_rs1_data,
    output logic [XLEN-1:0]    out_rs2_data,
    output logic [XLEN-1:0]    out_imm,
    output logic               out_alusrc,
    output logic [REG_W-1:0]   out_rd,
    output logic               out_memread,
    output logic               out_regwrite,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic [CNT_W-1:0]   stall_cnt
);

    stage_state_e state_reg;
    stage_state_e state_next;

    logic [XLEN-1:0]  rs1_data_reg;
    logic [XLEN-1:0]  rs2_data_reg;
    logic [XLEN-1:0]  imm_reg;
    logic             alusrc_reg;
    logic [REG_W-1:0] rd_reg;
    logic             memread_reg;
    logic             regwrite_reg;
    alu_op_e          aluop_reg;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic hazard;
    logic accept;
    logic stall_evt;
    logic full;

    assign full = (state_reg == ST_FULL);

`ifdef ID_EX_LOAD_USE_STALL_EN
    id_ex_hazard u_hazard (
        .in_valid     (in_valid),
        .held_valid   (full),
        .held_memread (memread_reg),
        .held_rd      (rd_reg),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_alusrc    (in_alusrc),
        .hazard       (hazard)
    );
`else
    // Without the interlock the source indices have no consumer in this stage.
    logic unused_src_idx;
    assign unused_src_idx = ^{in_rs1, in_rs2};
    assign hazard         = 1'b0;
`endif

    // Flush always presents ready so decode can retire the squashed instruction.
    assign in_ready  = flush | ((~full | out_ready) & ~hazard);
    assign accept    = in_valid & in_ready & ~flush;
    assign stall_evt = in_valid & ~in_ready & ~flush;

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) state_next = ST_FULL;
                end
                ST_FULL: begin
                    if (accept)
                        state_next = ST_FULL;
                    else if (hazard & out_ready)
                        state_next = ST_BUBBLE;
                    else if (out_ready)
                        state_next = ST_EMPTY;
                end
                ST_BUBBLE: begin
                    // The stalled instruction is guaranteed to be taken here.
                    state_next = accept ? ST_FULL : ST_EMPTY;
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (stall_evt && (cnt_reg != {CNT_W{1'b1}}))
            cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Payload only moves on accept, so it stays stable while the slot is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_data_reg <= '0;
            rs2_data_reg <= '0;
            imm_reg      <= '0;
            alusrc_reg   <= 1'b0;
            rd_reg       <= '0;
            memread_reg  <= 1'b0;
            regwrite_reg <= 1'b0;
            aluop_reg    <= ALU_ADD;
        end else if (accept) begin
            rs1_data_reg <= in_rs1_data;
            rs2_data_reg <= in_rs2_data;
            imm_reg      <= in_imm;
            alusrc_reg   <= in_alusrc;
            rd_reg       <= in_rd;
            memread_reg  <= in_memread;
            regwrite_reg <= in_regwrite;
            aluop_reg    <= alu_op_e'(in_aluop);
        end
    end

    assign out_valid    = full;
    assign out_rs1_data = rs1_data_reg;
    assign out_rs2_data = rs2_data_reg;
    assign out_imm      = imm_reg;
    assign out_alusrc   = alusrc_reg;
    assign out_rd       = rd_reg;
    assign out_memread  = memread_reg;
    assign out_regwrite = regwrite_reg;
    assign out_aluop    = aluop_reg;
    assign stall_cnt    = cnt_reg;

endmodule
